// File: rtl/led_frame_pingpong_ctrl.sv
// Ping-pong frame buffer controller: captures pixel frames into one bank of a
// shared dual-port RAM while the newest complete frame streams out of the other.
module led_frame_pingpong_ctrl #(
  parameter int SIZE   = 24,
  parameter int PIXELS = 64,
  localparam int AW    = $clog2(2 * PIXELS),
  localparam int IW    = $clog2(PIXELS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            in_sof,
  input  logic [SIZE-1:0] in_data,
  input  logic            frame_go,
  output logic            ram_we,
  output logic [AW-1:0]   ram_waddr,
  output logic [SIZE-1:0] ram_wdata,
  output logic [AW-1:0]   ram_raddr,
  input  logic [SIZE-1:0] ram_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_data,
  output logic            out_sof,
  output logic            out_eof,
  output logic            frame_pending,
  output logic            rd_busy,
  output logic [7:0]      drop_cnt
);

  typedef enum logic {WIDLE, WRITE} wstate_t;
  typedef enum logic {RIDLE, RUN}   rstate_t;

  wstate_t         wstate_q, wstate_d;
  logic            wbank_q, wbank_d;
  logic [IW-1:0]   wcnt_q, wcnt_d;
  logic            pbank_q, pbank_d;
  logic            frame_pending_q, frame_pending_d;
  logic [7:0]      drop_q, drop_d;
  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [SIZE-1:0] wdata_q, wdata_d;

  rstate_t         rstate_q, rstate_d;
  logic            rbank_q, rbank_d;
  logic [IW:0]     ridx_q, ridx_d;
  logic            infl_q, infl_d;
  logic            infl_sof_q, infl_sof_d;
  logic            infl_eof_q, infl_eof_d;
  logic [1:0]      occ_q, occ_d;
  logic [SIZE-1:0] b0_data_q, b0_data_d, b1_data_q, b1_data_d;
  logic            b0_sof_q, b0_sof_d, b1_sof_q, b1_sof_d;
  logic            b0_eof_q, b0_eof_d, b1_eof_q, b1_eof_d;

  logic            sof_acc, go_acc, lock_bank, new_bank, sof_kill, wr_done;
  logic            pop, issue;
  logic [1:0]      occ_after;

  always_comb begin
    wstate_d        = wstate_q;
    wbank_d         = wbank_q;
    wcnt_d          = wcnt_q;
    pbank_d         = pbank_q;
    frame_pending_d = frame_pending_q;
    drop_d          = drop_q;
    we_d            = 1'b0;
    waddr_d         = waddr_q;
    wdata_d         = wdata_q;
    rstate_d        = rstate_q;
    rbank_d         = rbank_q;
    ridx_d          = ridx_q;
    infl_sof_d      = infl_sof_q;
    infl_eof_d      = infl_eof_q;
    b0_data_d       = b0_data_q;
    b0_sof_d        = b0_sof_q;
    b0_eof_d        = b0_eof_q;
    b1_data_d       = b1_data_q;
    b1_sof_d        = b1_sof_q;
    b1_eof_d        = b1_eof_q;
    sof_kill        = 1'b0;
    wr_done         = 1'b0;

    sof_acc   = in_valid & in_sof;
    go_acc    = (rstate_q == RIDLE) & frame_go & frame_pending_q;
    // The bank the writer must avoid: the one being read, else the one holding the pending frame.
    lock_bank = (rstate_q == RUN) ? rbank_q : (frame_pending_q ? pbank_q : ~wbank_q);
    new_bank  = ~lock_bank;

    if (sof_acc) begin
      wstate_d = WRITE;
      wbank_d  = new_bank;
      wcnt_d   = IW'(1);
      we_d     = 1'b1;
      waddr_d  = {new_bank, IW'(0)};
      wdata_d  = in_data;
      sof_kill = frame_pending_q & (new_bank == pbank_q);
    end else if ((wstate_q == WRITE) && in_valid) begin
      we_d    = 1'b1;
      waddr_d = {wbank_q, wcnt_q};
      wdata_d = in_data;
      if (wcnt_q == IW'(PIXELS - 1)) begin
        wr_done  = 1'b1;
        wstate_d = WIDLE;
        pbank_d  = wbank_q;
      end else begin
        wcnt_d = wcnt_q + IW'(1);
      end
    end

    if (go_acc || sof_kill) frame_pending_d = 1'b0;
    if (wr_done)            frame_pending_d = 1'b1;
    // A frame handed to the reader in the same cycle is consumed, not dropped.
    if ((sof_kill || (wr_done && frame_pending_q && !go_acc)) && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;

    pop       = (occ_q != 2'd0) & out_ready;
    occ_after = occ_q - {1'b0, pop};
    issue     = (rstate_q == RUN) && (ridx_q < (IW+1)'(PIXELS)) &&
                ((occ_after + {1'b0, infl_q}) < 2'd2);

    if (pop) begin
      b0_data_d = b1_data_q;
      b0_sof_d  = b1_sof_q;
      b0_eof_d  = b1_eof_q;
    end
    if (infl_q) begin
      if (occ_after == 2'd0) begin
        b0_data_d = ram_rdata;
        b0_sof_d  = infl_sof_q;
        b0_eof_d  = infl_eof_q;
      end else begin
        b1_data_d = ram_rdata;
        b1_sof_d  = infl_sof_q;
        b1_eof_d  = infl_eof_q;
      end
    end
    occ_d = occ_after + {1'b0, infl_q};

    infl_d = issue;
    if (issue) begin
      infl_sof_d = (ridx_q == '0);
      infl_eof_d = (ridx_q == (IW+1)'(PIXELS - 1));
      ridx_d     = ridx_q + (IW+1)'(1);
    end

    if (go_acc) begin
      rstate_d = RUN;
      rbank_d  = pbank_q;
      ridx_d   = '0;
    end else if ((rstate_q == RUN) && pop && b0_eof_q) begin
      rstate_d = RIDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wstate_q        <= WIDLE;
      wbank_q         <= 1'b0;
      wcnt_q          <= '0;
      pbank_q         <= 1'b0;
      frame_pending_q <= 1'b0;
      drop_q          <= '0;
      we_q            <= 1'b0;
      waddr_q         <= '0;
      wdata_q         <= '0;
      rstate_q        <= RIDLE;
      rbank_q         <= 1'b0;
      ridx_q          <= '0;
      infl_q          <= 1'b0;
      infl_sof_q      <= 1'b0;
      infl_eof_q      <= 1'b0;
      occ_q           <= '0;
      b0_data_q       <= '0;
      b0_sof_q        <= 1'b0;
      b0_eof_q        <= 1'b0;
      b1_data_q       <= '0;
      b1_sof_q        <= 1'b0;
      b1_eof_q        <= 1'b0;
    end else begin
      wstate_q        <= wstate_d;
      wbank_q         <= wbank_d;
      wcnt_q          <= wcnt_d;
      pbank_q         <= pbank_d;
      frame_pending_q <= frame_pending_d;
      drop_q          <= drop_d;
      we_q            <= we_d;
      waddr_q         <= waddr_d;
      wdata_q         <= wdata_d;
      rstate_q        <= rstate_d;
      rbank_q         <= rbank_d;
      ridx_q          <= ridx_d;
      infl_q          <= infl_d;
      infl_sof_q      <= infl_sof_d;
      infl_eof_q      <= infl_eof_d;
      occ_q           <= occ_d;
      b0_data_q       <= b0_data_d;
      b0_sof_q        <= b0_sof_d;
      b0_eof_q        <= b0_eof_d;
      b1_data_q       <= b1_data_d;
      b1_sof_q        <= b1_sof_d;
      b1_eof_q        <= b1_eof_d;
    end
  end

  assign ram_we        = we_q;
  assign ram_waddr     = waddr_q;
  assign ram_wdata     = wdata_q;
  assign ram_raddr     = {rbank_q, ridx_q[IW-1:0]};
  assign out_valid     = (occ_q != 2'd0);
  assign out_data      = b0_data_q;
  assign out_sof       = out_valid & b0_sof_q;
  assign out_eof       = out_valid & b0_eof_q;
  assign frame_pending = frame_pending_q;
  assign rd_busy       = (rstate_q == RUN);
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_led_frame_pingpong_ctrl.sv
// Directed bench for led_frame_pingpong_ctrl with a behavioural 1-cycle-latency RAM
// and hand-computed expected pixel streams and bank addresses.
module tb_led_frame_pingpong_ctrl;
  localparam int PIX = 64;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_sof, frame_go, out_ready;
  logic [23:0] in_data;
  logic        ram_we, out_valid, out_sof, out_eof, frame_pending, rd_busy;
  logic [6:0]  ram_waddr, ram_raddr;
  logic [23:0] ram_wdata, ram_rdata, out_data;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [23:0] cap_data [PIX];
  logic        cap_sof  [PIX];
  logic        cap_eof  [PIX];
  int          got, first_valid, gaps, unstable;
  logic [6:0]  raddr_start;
  logic        busy_start, pend_start, busy_after;

  logic [23:0] mem [0:2*PIX-1];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  led_frame_pingpong_ctrl #(.SIZE(24), .PIXELS(PIX)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .frame_go(frame_go), .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
    .frame_pending(frame_pending), .rd_busy(rd_busy), .drop_cnt(drop_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_pixels(input int base, input int first, input int n, input bit sof_first);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_sof   = sof_first && (i == 0);
      in_data  = 24'(base + first + i);
      step();
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // Caller raises frame_go; this samples it at the next edge and captures accepted pixels.
  task automatic collect_frame(input bit rand_ready, input int stop_after);
    bit          stalled;
    logic [25:0] held;
    int          c;
    for (int i = 0; i < PIX; i++) begin
      cap_data[i] = 24'hFFFFFF; cap_sof[i] = 1'b1; cap_eof[i] = 1'b0;
    end
    got = 0; first_valid = -1; gaps = 0; unstable = 0;
    stalled = 1'b0; held = '0;
    step();
    frame_go    = 1'b0;
    raddr_start = ram_raddr;
    busy_start  = rd_busy;
    pend_start  = frame_pending;
    c = 1;
    while (1) begin
      out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (stalled && ({out_valid, out_data, out_sof, out_eof} !== {1'b1, held})) unstable++;
      if (out_valid && first_valid < 0) first_valid = c;
      if (!out_valid && first_valid >= 0 && !rand_ready) gaps++;
      stalled = out_valid && !out_ready;
      held    = {out_data, out_sof, out_eof};
      if (out_valid && out_ready) begin
        if (got < PIX) begin
          cap_data[got] = out_data; cap_sof[got] = out_sof; cap_eof[got] = out_eof;
        end
        got++;
      end
      step();
      c++;
      if (got >= PIX || (stop_after > 0 && got >= stop_after) || c > 1000) break;
    end
    busy_after = rd_busy;
    out_ready  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; frame_go = 1'b0; out_ready = 1'b1;
    step(); step();
    checks++; if ({ram_we, ram_waddr, ram_wdata} !== 32'h0) begin errors++; $display("[TB] FAIL reset write port: got %h expected 0", {ram_we, ram_waddr, ram_wdata}); end
    checks++; if (ram_raddr !== 7'h0) begin errors++; $display("[TB] FAIL reset ram_raddr: got %h expected 0", ram_raddr); end
    checks++; if ({out_valid, out_data, out_sof, out_eof} !== 27'h0) begin errors++; $display("[TB] FAIL reset output: got %h expected 0", {out_valid, out_data, out_sof, out_eof}); end
    checks++; if ({frame_pending, rd_busy, drop_cnt} !== 10'h0) begin errors++; $display("[TB] FAIL reset status: got %h expected 0", {frame_pending, rd_busy, drop_cnt}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_stray_valid();
    in_valid = 1'b1; in_sof = 1'b0; in_data = 24'hABCDEF;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({ram_we, frame_pending} !== 2'b00) begin errors++; $display("[TB] FAIL stray valid: got we/pend %b expected 00", {ram_we, frame_pending}); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_single_frame();
    for (int i = 0; i < PIX; i++) begin
      in_valid = 1'b1; in_sof = (i == 0); in_data = 24'(i);
      step();
      checks++; if ({ram_we, ram_waddr, ram_wdata} !== {1'b1, 7'(i), 24'(i)}) begin errors++; $display("[TB] FAIL single write %0d: got %h expected %h", i, {ram_we, ram_waddr, ram_wdata}, {1'b1, 7'(i), 24'(i)}); end
      checks++; if (frame_pending !== (i == PIX - 1)) begin errors++; $display("[TB] FAIL single pending at %0d: got %b expected %b", i, frame_pending, (i == PIX - 1)); end
    end
    in_valid = 1'b0; in_sof = 1'b0;
    frame_go = 1'b1;
    collect_frame(1'b0, 0);
    checks++; if ({raddr_start, busy_start, pend_start} !== {7'h00, 1'b1, 1'b0}) begin errors++; $display("[TB] FAIL single go: got raddr/busy/pend %h expected 02", {raddr_start, busy_start, pend_start}); end
    checks++; if (first_valid !== 3) begin errors++; $display("[TB] FAIL single latency: got %0d expected 3", first_valid); end
    checks++; if ({got, gaps, unstable} !== {32'd64, 32'd0, 32'd0}) begin errors++; $display("[TB] FAIL single count/gaps/unstable: got %0d/%0d/%0d expected 64/0/0", got, gaps, unstable); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("[TB] FAIL single busy after eof: got %b expected 0", busy_after); end
    for (int i = 0; i < PIX; i++) begin
      checks++; if ({cap_data[i], cap_sof[i], cap_eof[i]} !== {24'(i), i == 0, i == PIX - 1}) begin errors++; $display("[TB] FAIL single pixel %0d: got %h expected %h", i, {cap_data[i], cap_sof[i], cap_eof[i]}, {24'(i), i == 0, i == PIX - 1}); end
    end
  endtask

  task automatic test_backpressure();
    write_pixels(0, 0, PIX, 1'b1);
    frame_go = 1'b1;
    collect_frame(1'b1, 0);
    checks++; if (raddr_start !== 7'h00) begin errors++; $display("[TB] FAIL bp raddr: got %h expected 00", raddr_start); end
    checks++; if ({got, unstable} !== {32'd64, 32'd0}) begin errors++; $display("[TB] FAIL bp count/unstable: got %0d/%0d expected 64/0", got, unstable); end
    checks++; if ({busy_after, out_valid} !== 2'b00) begin errors++; $display("[TB] FAIL bp idle after eof: got %b expected 00", {busy_after, out_valid}); end
    for (int i = 0; i < PIX; i++) begin
      checks++; if ({cap_data[i], cap_sof[i], cap_eof[i]} !== {24'(i), i == 0, i == PIX - 1}) begin errors++; $display("[TB] FAIL bp pixel %0d: got %h expected %h", i, {cap_data[i], cap_sof[i], cap_eof[i]}, {24'(i), i == 0, i == PIX - 1}); end
    end
  endtask

  task automatic test_write_during_read();
    write_pixels(32'h100, 0, PIX, 1'b1);
    frame_go = 1'b1;
    fork
      collect_frame(1'b0, 0);
      begin
        step();
        for (int i = 0; i < PIX; i++) begin
          in_valid = 1'b1; in_sof = (i == 0); in_data = 24'(32'h200 + i);
          step();
          checks++; if ({ram_we, ram_waddr} !== {1'b1, 7'(64 + i)}) begin errors++; $display("[TB] FAIL wdr write %0d: got %h expected %h", i, {ram_we, ram_waddr}, {1'b1, 7'(64 + i)}); end
          checks++; if (ram_raddr[6] !== 1'b0) begin errors++; $display("[TB] FAIL wdr read bank at %0d: got %b expected 0", i, ram_raddr[6]); end
        end
        in_valid = 1'b0; in_sof = 1'b0;
      end
    join
    checks++; if (got !== 64) begin errors++; $display("[TB] FAIL wdr old count: got %0d expected 64", got); end
    for (int i = 0; i < PIX; i++) begin
      checks++; if (cap_data[i] !== 24'(32'h100 + i)) begin errors++; $display("[TB] FAIL wdr old pixel %0d: got %h expected %h", i, cap_data[i], 24'(32'h100 + i)); end
    end
    step();
    checks++; if ({frame_pending, drop_cnt} !== 9'h100) begin errors++; $display("[TB] FAIL wdr pend/drop: got %h expected 100", {frame_pending, drop_cnt}); end
    frame_go = 1'b1;
    collect_frame(1'b0, 0);
    checks++; if ({raddr_start, got} !== {7'h40, 32'd64}) begin errors++; $display("[TB] FAIL wdr new raddr/count: got %h/%0d expected 40/64", raddr_start, got); end
    for (int i = 0; i < PIX; i++) begin
      checks++; if (cap_data[i] !== 24'(32'h200 + i)) begin errors++; $display("[TB] FAIL wdr new pixel %0d: got %h expected %h", i, cap_data[i], 24'(32'h200 + i)); end
    end
  endtask

  task automatic test_overwrite();
    write_pixels(32'h300, 0, PIX, 1'b1);
    write_pixels(32'h400, 0, PIX, 1'b1);
    checks++; if ({frame_pending, drop_cnt} !== 9'h101) begin errors++; $display("[TB] FAIL ovw pend/drop: got %h expected 101", {frame_pending, drop_cnt}); end
    frame_go = 1'b1;
    collect_frame(1'b0, 0);
    checks++; if ({raddr_start, got} !== {7'h00, 32'd64}) begin errors++; $display("[TB] FAIL ovw raddr/count: got %h/%0d expected 00/64", raddr_start, got); end
    for (int i = 0; i < PIX; i++) begin
      checks++; if (cap_data[i] !== 24'(32'h400 + i)) begin errors++; $display("[TB] FAIL ovw pixel %0d: got %h expected %h", i, cap_data[i], 24'(32'h400 + i)); end
    end
  endtask

  task automatic test_sof_restart();
    write_pixels(32'h500, 0, 10, 1'b1);
    in_valid = 1'b1; in_sof = 1'b1; in_data = 24'h000600;
    step();
    checks++; if ({ram_we, ram_waddr, ram_wdata, drop_cnt} !== {1'b1, 7'h00, 24'h000600, 8'd1}) begin errors++; $display("[TB] FAIL restart sof: got %h expected %h", {ram_we, ram_waddr, ram_wdata, drop_cnt}, {1'b1, 7'h00, 24'h000600, 8'd1}); end
    write_pixels(32'h600, 1, PIX - 1, 1'b0);
    checks++; if ({frame_pending, drop_cnt} !== 9'h101) begin errors++; $display("[TB] FAIL restart pend/drop: got %h expected 101", {frame_pending, drop_cnt}); end
    in_valid = 1'b1; in_sof = 1'b0; in_data = 24'h00BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({ram_we, frame_pending} !== 2'b01) begin errors++; $display("[TB] FAIL extra pixel %0d: got we/pend %b expected 01", i, {ram_we, frame_pending}); end
    end
    in_valid = 1'b0;
    frame_go = 1'b1;
    collect_frame(1'b0, 0);
    checks++; if ({raddr_start, got} !== {7'h00, 32'd64}) begin errors++; $display("[TB] FAIL restart raddr/count: got %h/%0d expected 00/64", raddr_start, got); end
    for (int i = 0; i < PIX; i++) begin
      checks++; if (cap_data[i] !== 24'(32'h600 + i)) begin errors++; $display("[TB] FAIL restart pixel %0d: got %h expected %h", i, cap_data[i], 24'(32'h600 + i)); end
    end
  endtask

  task automatic test_reset_mid_readout();
    write_pixels(32'h700, 0, PIX, 1'b1);
    frame_go = 1'b1;
    collect_frame(1'b0, 20);
    checks++; if ({got, cap_data[19]} !== {32'd20, 24'h000713}) begin errors++; $display("[TB] FAIL rmr partial: got %0d/%h expected 20/000713", got, cap_data[19]); end
    rst_n = 1'b0;
    step();
    checks++; if ({ram_we, ram_waddr, ram_wdata, ram_raddr, out_valid, out_data, out_sof, out_eof, frame_pending, rd_busy, drop_cnt} !== 76'h0) begin errors++; $display("[TB] FAIL rmr outputs: got %h expected 0", {ram_we, ram_waddr, ram_wdata, ram_raddr, out_valid, out_data, out_sof, out_eof, frame_pending, rd_busy, drop_cnt}); end
    rst_n = 1'b1;
    step();
    write_pixels(32'h800, 0, PIX, 1'b1);
    frame_go = 1'b1;
    collect_frame(1'b0, 0);
    checks++; if ({raddr_start, first_valid, got, gaps} !== {7'h00, 32'd3, 32'd64, 32'd0}) begin errors++; $display("[TB] FAIL rmr new frame raddr/lat/count/gaps: got %h/%0d/%0d/%0d expected 00/3/64/0", raddr_start, first_valid, got, gaps); end
    for (int i = 0; i < PIX; i++) begin
      checks++; if ({cap_data[i], cap_sof[i], cap_eof[i]} !== {24'(32'h800 + i), i == 0, i == PIX - 1}) begin errors++; $display("[TB] FAIL rmr pixel %0d: got %h expected %h", i, {cap_data[i], cap_sof[i], cap_eof[i]}, {24'(32'h800 + i), i == 0, i == PIX - 1}); end
    end
  endtask

  task automatic test_drop_saturate();
    for (int k = 0; k < 300; k++) begin
      write_pixels(k * 256, 0, PIX, 1'b1);
      if (k == 254) begin
        checks++; if (drop_cnt !== 8'd254) begin errors++; $display("[TB] FAIL drop after 255 frames: got %0d expected 254", drop_cnt); end
      end
      if (k == 255) begin
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("[TB] FAIL drop after 256 frames: got %0d expected 255", drop_cnt); end
      end
    end
    checks++; if ({frame_pending, drop_cnt} !== 9'h1FF) begin errors++; $display("[TB] FAIL drop saturated: got %h expected 1ff", {frame_pending, drop_cnt}); end
    frame_go = 1'b1;
    collect_frame(1'b0, 0);
    checks++; if ({raddr_start, got} !== {7'h40, 32'd64}) begin errors++; $display("[TB] FAIL drop readout raddr/count: got %h/%0d expected 40/64", raddr_start, got); end
    for (int i = 0; i < PIX; i++) begin
      checks++; if (cap_data[i] !== 24'(299 * 256 + i)) begin errors++; $display("[TB] FAIL drop pixel %0d: got %h expected %h", i, cap_data[i], 24'(299 * 256 + i)); end
    end
  endtask

  initial begin
    $display("[TB] starting led_frame_pingpong_ctrl bench");
    test_reset();
    test_stray_valid();
    test_single_frame();
    test_backpressure();
    test_write_during_read();
    test_overwrite();
    test_sof_restart();
    test_reset_mid_readout();
    test_drop_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_frame_pingpong_ctrl.md
# led_frame_pingpong_ctrl

- Double-buffer frame controller that sequences a simple dual-port RAM. The RAM is sized 2*PIXELS and shared as two banks.
- The write side takes the captured pixel stream (from HDMI capture) and stores complete frames.
- The read side streams the most recent complete frame, on request, to the APA102 serializer over a valid/ready handshake. It sustains 1 pixel/clk across the RAM's 1-cycle read latency.
- Sits between the video capture/scaler and the LED driver. Owns all RAM addressing so reads and writes never touch the same bank.

## Interface
- SIZE, 24: pixel width in bits (= RAM word size).
- PIXELS, 64: pixels per frame. Must be a power of two, ≥ 2. RAM DEPTH = 2*PIXELS; AW = $clog2(2*PIXELS).

Ports:
- clk  in  1  single clock for all logic and both RAM ports.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  pixel present on in_data.
- in_sof  in  1  qualifies in_valid: this pixel is index 0 of a new frame.
- in_data  in  SIZE  pixel value.
- frame_go  in  1  request readout of the pending frame.
- ram_we  out  1  RAM write enable.
- ram_waddr  out  AW  RAM write address.
- ram_wdata  out  SIZE  RAM write data.
- ram_raddr  out  AW  RAM read address.
- ram_rdata  in  SIZE  RAM read data; valid 1 cycle after ram_raddr is sampled.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  SIZE  pixel.
- out_sof  out  1  out_data is pixel 0.
- out_eof  out  1  out_data is pixel PIXELS-1.
- frame_pending  out  1  a complete, unread frame is held.
- rd_busy  out  1  readout in progress.
- drop_cnt  out  8  saturating count of discarded complete frames.

## Operation
- **Bank addressing:** address = {bank, idx}. bank is the MSB; idx is $clog2(PIXELS) bits.
- **Writer states:** WIDLE and WRITE.
- **Writer, in WIDLE:**
  - in_valid without in_sof is ignored.
  - Accepted sof (in_valid & in_sof, any state) chooses a bank, writes pixel 0 there, sets wcnt=1, and enters WRITE.
- **Bank choice at sof:** wbank := ~L, where L = rbank if rd_busy, else pbank if frame_pending, else ~wbank (bank unchanged).
- **Sof that destroys the pending frame:** if frame_pending and the new wbank == pbank, clear frame_pending and increment drop_cnt.
- **Sof mid-frame:** restarts at idx 0. The partial frame is discarded and not counted.
- **Writer, in WRITE:**
  - in_valid & !in_sof writes idx wcnt and increments wcnt.
  - Writing idx PIXELS-1 completes the frame: frame_pending=1, pbank=wbank, return to WIDLE.
  - If frame_pending was already 1 at completion, the older frame is replaced and drop_cnt increments.
- **Reader states:** RIDLE and RUN.
- **Reader, in RIDLE:** frame_go & frame_pending (registered values) sets rbank=pbank, clears frame_pending, sets ridx=0, and enters RUN. rd_busy=1.
- **frame_go** is ignored in RUN or when nothing is pending.
- **Completion and go in the same cycle:** go sees the old frame_pending.
- **Read pipeline:**
  - A 2-entry output buffer feeds the output.
  - Issue ram_raddr={rbank,ridx} and increment ridx while ridx < PIXELS and (buffer occupancy + reads in flight) < 2. Occupancy is counted after this cycle's pop.
  - Returned ram_rdata pushes into the buffer.
- **Output side:**
  - out_sof/out_eof are tagged per entry.
  - out_data holds stable while out_valid & !out_ready.
  - RUN → RIDLE and rd_busy=0 on the out_eof handshake.
- **drop_cnt** saturates at 255.

## Timing
- **Reset:**
  - Every output is 0: ram_we, ram_waddr, ram_wdata, ram_raddr, out_valid, out_data, out_sof, out_eof, frame_pending, rd_busy, drop_cnt.
  - Internal state: wbank=0, pbank=0, rbank=0, both FSMs idle, buffer empty, in-flight cleared.
  - Reset mid-frame or mid-readout abandons all work, with the same values.
- **Write latency:** ram_we/ram_waddr/ram_wdata are registered and assert 1 cycle after the in_valid cycle.
- **frame_pending** rises in the same cycle ram_we carries pixel PIXELS-1.
- **Readout latency:** frame_go sampled with frame_pending=1 in cycle n gives:
  - ram_raddr = pixel 0 in cycle n+1;
  - out_valid=1 with out_sof in cycle n+3.
- **Throughput:** with out_ready held 1, one pixel per cycle and no bubbles. Frame length is PIXELS cycles from sof to eof.
- **Backpressure:** out_ready=0 stalls address issue within 2 cycles. No data is lost or reordered.
- **Bank safety:** a write address never equals any read address issued in the same cycle, and the writer never writes rbank while rd_busy.

## Test plan
- **Single frame, PIXELS=64:** write pixels 0x000000..0x00003F with sof on the first, then pulse frame_go → frame_pending rises with the last ram_we. Output is 64 pixels equal to the inputs, out_sof on the first, out_eof on the last, first out_valid 3 cycles after go, no gaps, rd_busy drops after eof.
- **Backpressure:** same frame with out_ready toggled pseudo-randomly → identical sequence, out_data stable while stalled, no duplicates.
- **Write during read:** start a readout of bank 0 and immediately write a new frame → ram_waddr MSB=1 throughout. The old frame reads out intact; frame_pending=1 afterwards with pbank=1.
- **Frame overwrite:** write two complete frames with no frame_go → drop_cnt=1, readout returns the second frame. Then 300 unread frames → drop_cnt=255.
- **Edge cases:**
  - Stray in_valid before any sof → no ram_we.
  - sof at pixel 10 → frame restarts at idx 0, drop_cnt unchanged.
  - Extra pixels after completion with no new sof → ignored.
- **Reset mid-readout:** rst_n=0 for 1 cycle at pixel 20 → all outputs 0 the next cycle, frame_pending=0. A new frame then reads out normally.
